// File: rtl/cv32e40p_apu_protocol_monitor.sv
// Run-time checker for the CV32E40P EX-stage APU handshake and write-back ports.
// It observes the stage only and reports violations through sticky error flags.
module cv32e40p_apu_protocol_monitor #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned LATENCY_MAX     = 16,
  parameter logic [5:0]  CHECK_EN        = 6'b111111,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             apu_req_i,
  input  logic             apu_gnt_i,
  input  logic             apu_rvalid_i,
  input  logic             apu_en_i,
  input  logic             apu_singlecycle_i,
  input  logic             apu_multicycle_i,
  input  logic             regfile_alu_we_i,
  input  logic             regfile_we_lsu_i,
  output logic [5:0]       err_o,
  output logic             err_any_o,
  output logic             first_err_valid_o,
  output logic [2:0]       first_err_id_o,
  output logic [CNT_W-1:0] outstanding_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned AGE_W = $clog2(LATENCY_MAX + 1);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(LATENCY_MAX);
  localparam logic [AGE_W-1:0] AGE_TO   = AGE_W'(LATENCY_MAX - 1);

  localparam int CHK_UNSOLICITED = 0;
  localparam int CHK_OVERFLOW    = 1;
  localparam int CHK_TIMEOUT     = 2;
  localparam int CHK_REQ_DROP    = 3;
  localparam int CHK_ALU_PORT    = 4;
  localparam int CHK_LSU_WB      = 5;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] slot_valid_q, slot_to_q;
  logic [AGE_W-1:0]           slot_age_q [MAX_OUTSTANDING];
  logic                       req_pend_q;
  logic [5:0]                 err_q;
  logic                       first_valid_q;
  logic [2:0]                 first_id_q;

  logic       full, empty, acc_gnt, acc_rv, wb_pending, timeout_hit;
  logic [5:0] raw_hit, hit;
  logic [2:0] first_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (cnt_q == MAX_CNT);
  assign empty      = (cnt_q == '0);
  assign acc_gnt    = apu_gnt_i & ~(full & ~apu_rvalid_i);
  assign acc_rv     = apu_rvalid_i & ~empty;
  assign wb_pending = apu_singlecycle_i | apu_multicycle_i;

  // The oldest slot reports once, on the last legal edge that passed without a response.
  assign timeout_hit = slot_valid_q[rd_ptr_q] & (slot_age_q[rd_ptr_q] == AGE_TO)
                     & ~slot_to_q[rd_ptr_q] & ~apu_rvalid_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cnt_d = cnt_q;
    if (acc_gnt && !acc_rv)      cnt_d = cnt_q + CNT_W'(1);
    else if (!acc_gnt && acc_rv) cnt_d = cnt_q - CNT_W'(1);

    raw_hit                  = '0;
    raw_hit[CHK_UNSOLICITED] = apu_rvalid_i & empty;
    raw_hit[CHK_OVERFLOW]    = apu_gnt_i & full & ~apu_rvalid_i;
    raw_hit[CHK_TIMEOUT]     = timeout_hit;
    raw_hit[CHK_REQ_DROP]    = req_pend_q & ~apu_req_i;
    raw_hit[CHK_ALU_PORT]    = wb_pending & apu_en_i & regfile_alu_we_i;
    raw_hit[CHK_LSU_WB]      = regfile_we_lsu_i & apu_rvalid_i & wb_pending;
    hit                      = raw_hit & CHECK_EN;

    first_idx = '0;
    for (int i = 5; i >= 0; i--) begin
      if (hit[i]) first_idx = 3'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; where two of them target
  // the same slot bit the later one wins, so a grant refilling a popped slot keeps it valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      slot_valid_q <= '0;
      slot_to_q    <= '0;
      req_pend_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_pend_q <= apu_req_i & ~apu_gnt_i;
      if (timeout_hit) slot_to_q[rd_ptr_q] <= 1'b1;
      if (acc_rv) begin
        slot_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q               <= ptr_inc(rd_ptr_q);
      end
      if (acc_gnt) begin
        slot_valid_q[wr_ptr_q] <= 1'b1;
        slot_to_q[wr_ptr_q]    <= 1'b0;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
    end
  end

  // NOTE: ages carry no reset; a slot's age is only read while its valid bit is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (acc_gnt && wr_ptr_q == PTR_W'(i)) begin
        slot_age_q[i] <= '0;
      end else if (slot_valid_q[i] && slot_age_q[i] != AGE_SAT) begin
        slot_age_q[i] <= slot_age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q         <= '0;
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else if (clear_i) begin
      err_q         <= '0;
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else begin
      err_q <= err_q | hit;
      if (!first_valid_q && |hit) begin
        first_valid_q <= 1'b1;
        first_id_q    <= first_idx;
      end
    end
  end

  assign err_o             = err_q;
  assign err_any_o         = |err_q;
  assign first_err_valid_o = first_valid_q;
  assign first_err_id_o    = first_id_q;
  assign outstanding_o     = cnt_q;

endmodule

// File: tb/tb_cv32e40p_apu_protocol_monitor.sv
// Directed bench for the APU protocol monitor: a fully enabled instance and one
// with the request-drop check masked, both driven by the same stimulus.
module tb_cv32e40p_apu_protocol_monitor;

  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned LAT_MAX = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

  logic clk_i = 1'b0;
  logic rst_ni, clear_i, apu_req_i, apu_gnt_i, apu_rvalid_i, apu_en_i;
  logic apu_singlecycle_i, apu_multicycle_i, regfile_alu_we_i, regfile_we_lsu_i;

  logic [5:0]       err_o, err_m;
  logic             err_any_o, err_any_m, first_err_valid_o, first_valid_m;
  logic [2:0]       first_err_id_o, first_id_m;
  logic [CNT_W-1:0] outstanding_o, outstanding_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  cv32e40p_apu_protocol_monitor #(
    .MAX_OUTSTANDING(MAX_OUT), .LATENCY_MAX(LAT_MAX), .CHECK_EN(6'b111111)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .apu_req_i(apu_req_i), .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i),
    .apu_en_i(apu_en_i), .apu_singlecycle_i(apu_singlecycle_i),
    .apu_multicycle_i(apu_multicycle_i), .regfile_alu_we_i(regfile_alu_we_i),
    .regfile_we_lsu_i(regfile_we_lsu_i), .err_o(err_o), .err_any_o(err_any_o),
    .first_err_valid_o(first_err_valid_o), .first_err_id_o(first_err_id_o),
    .outstanding_o(outstanding_o)
  );

  cv32e40p_apu_protocol_monitor #(
    .MAX_OUTSTANDING(MAX_OUT), .LATENCY_MAX(LAT_MAX), .CHECK_EN(6'b110111)
  ) dut_m (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .apu_req_i(apu_req_i), .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i),
    .apu_en_i(apu_en_i), .apu_singlecycle_i(apu_singlecycle_i),
    .apu_multicycle_i(apu_multicycle_i), .regfile_alu_we_i(regfile_alu_we_i),
    .regfile_we_lsu_i(regfile_we_lsu_i), .err_o(err_m), .err_any_o(err_any_m),
    .first_err_valid_o(first_valid_m), .first_err_id_o(first_id_m),
    .outstanding_o(outstanding_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clear_i = 0; apu_req_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0; apu_en_i = 0;
    apu_singlecycle_i = 0; apu_multicycle_i = 0; regfile_alu_we_i = 0; regfile_we_lsu_i = 0;
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    idle(); clear_i = 1; step(); clear_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    idle();
    #12;
    check("rst_err", err_o, 6'h00);
    check("rst_any", err_any_o, 0);
    check("rst_fv", first_err_valid_o, 0);
    check("rst_fid", first_err_id_o, 0);
    check("rst_cnt", outstanding_o, 0);
    rst_ni = 1;
    step(); step();

    // Normal traffic: grant, three cycles in flight, response.
    apu_req_i = 1; apu_gnt_i = 1; step(); idle();
    check("nrm_cnt_c11", outstanding_o, 1);
    step(); check("nrm_cnt_c12", outstanding_o, 1);
    step(); check("nrm_cnt_c13", outstanding_o, 1);
    apu_rvalid_i = 1; step(); idle();
    check("nrm_cnt_c14", outstanding_o, 0);
    check("nrm_err", err_o, 6'h00);

    // Overflow: third grant with two in flight.
    apu_req_i = 1; apu_gnt_i = 1;
    step(); step(); step(); idle();
    check("ovf_err", err_o, 6'b000010);
    check("ovf_fid", first_err_id_o, 1);
    check("ovf_fv", first_err_valid_o, 1);
    check("ovf_cnt", outstanding_o, 2);
    apu_rvalid_i = 1; step(); step(); idle();
    check("ovf_drain_cnt", outstanding_o, 0);
    check("ovf_drain_err", err_o, 6'b000010);
    do_clear();
    check("clr1_err", err_o, 6'h00);

    // Timeout: grant, no response for LATENCY_MAX edges.
    apu_req_i = 1; apu_gnt_i = 1; step(); idle();
    check("to_c21", err_o[2], 0);
    step(); step(); step();
    check("to_c24", err_o[2], 0);
    step();
    check("to_c25", err_o[2], 1);
    check("to_fid", first_err_id_o, 2);
    repeat (5) step();
    check("to_hold", err_o, 6'b000100);
    apu_rvalid_i = 1; step(); idle();
    check("to_late_cnt", outstanding_o, 0);
    check("to_late_err", err_o, 6'b000100);
    do_clear();

    // Unsolicited response, then clear; then clear racing a hit.
    apu_rvalid_i = 1; step(); idle();
    check("uns_err", err_o, 6'b000001);
    check("uns_fv", first_err_valid_o, 1);
    check("uns_fid", first_err_id_o, 0);
    check("uns_cnt", outstanding_o, 0);
    step();
    do_clear();
    check("uns_clr_err", err_o, 6'h00);
    check("uns_clr_fv", first_err_valid_o, 0);
    check("uns_clr_any", err_any_o, 0);
    clear_i = 1; apu_rvalid_i = 1; step(); idle();
    check("clr_wins_err", err_o, 6'h00);
    check("clr_wins_fv", first_err_valid_o, 0);

    // Simultaneous ALU-port and LSU write-back conflicts with one in flight.
    apu_req_i = 1; apu_gnt_i = 1; step(); idle();
    apu_en_i = 1; apu_singlecycle_i = 1; regfile_alu_we_i = 1;
    regfile_we_lsu_i = 1; apu_rvalid_i = 1;
    step(); idle();
    check("sim_err", err_o, 6'b110000);
    check("sim_fid", first_err_id_o, 4);
    check("sim_cnt", outstanding_o, 0);
    do_clear();

    // Multicycle write-back also counts as pending for the ALU port.
    apu_en_i = 1; apu_multicycle_i = 1; regfile_alu_we_i = 1; step(); idle();
    check("mc_err", err_o, 6'b010000);
    do_clear();

    // Request drop, full and masked instance.
    apu_req_i = 1; step();
    apu_req_i = 0; step();
    check("drop_err", err_o, 6'b001000);
    check("drop_fid", first_err_id_o, 3);
    check("drop_any", err_any_o, 1);
    check("drop_mask_err", err_m, 6'h00);
    check("drop_mask_any", err_any_m, 0);
    check("drop_mask_fv", first_valid_m, 0);
    do_clear();

    // Grant and response together at full and at empty.
    apu_req_i = 1; apu_gnt_i = 1; step(); step();
    apu_rvalid_i = 1; step();
    check("full_both_cnt", outstanding_o, 2);
    check("full_both_err", err_o, 6'h00);
    idle(); apu_rvalid_i = 1; step(); step(); idle();
    check("full_drain_cnt", outstanding_o, 0);
    check("full_drain_err", err_o, 6'h00);
    apu_req_i = 1; apu_gnt_i = 1; apu_rvalid_i = 1; step(); idle();
    check("empty_both_err", err_o, 6'b000001);
    check("empty_both_cnt", outstanding_o, 1);
    check("empty_both_mcnt", outstanding_m, 1);
    apu_rvalid_i = 1; step(); idle();
    check("empty_drain_cnt", outstanding_o, 0);
    do_clear();

    // Asynchronous reset mid-transaction.
    apu_req_i = 1; apu_gnt_i = 1; step(); idle();
    check("ar_pre_cnt", outstanding_o, 1);
    #2 rst_ni = 0;
    #1;
    check("ar_cnt", outstanding_o, 0);
    check("ar_fv", first_err_valid_o, 0);
    #1 rst_ni = 1;
    apu_rvalid_i = 1; step(); idle();
    check("ar_resp_err", err_o, 6'b000001);
    check("ar_resp_cnt", outstanding_o, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_protocol_monitor.md
# cv32e40p_apu_protocol_monitor

Synthesizable run-time protocol monitor for the CV32E40P EX-stage APU and write-back interface. It generalises the EX-stage unreachable-condition properties into a parametrised hardware checker. The checker counts outstanding APU transactions, bounds response latency, checks request stability and detects register-file write-port conflicts. Violations are reported through sticky error flags, so the block can be used in silicon debug and in simulation. It sits beside `cv32e40p_ex_stage`, observes that stage's signals only, and never drives core logic.

## Interface
- `MAX_OUTSTANDING`, default 2: APU transactions allowed in flight (1..8).
- `LATENCY_MAX`, default 16: last cycle after grant in which `apu_rvalid_i` is legal (1..255).
- `CHECK_EN`, default 6'b111111: per-check enable mask, bit i enables check i.
- `clk_i` in 1: core clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `clear_i` in 1: synchronous clear of sticky error state.
- `apu_req_i` in 1: APU request.
- `apu_gnt_i` in 1: APU grant.
- `apu_rvalid_i` in 1: APU result valid.
- `apu_en_i` in 1: APU instruction in EX.
- `apu_singlecycle_i` in 1: single-cycle APU write-back pending.
- `apu_multicycle_i` in 1: multicycle APU write-back pending.
- `regfile_alu_we_i` in 1: ALU write-port enable.
- `regfile_we_lsu_i` in 1: LSU write-back enable.
- `err_o` out 6: sticky per-check error flags.
- `err_any_o` out 1: OR of `err_o`.
- `first_err_valid_o` out 1: `first_err_id_o` holds valid data.
- `first_err_id_o` out 3: index of the first error recorded.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current in-flight count.

## Operation
- **Outstanding counter.**
  - Update rule: `cnt_next = cnt + acc_gnt - acc_rv`.
  - `acc_gnt = apu_gnt_i & !(cnt==MAX_OUTSTANDING & !apu_rvalid_i)`.
  - `acc_rv = apu_rvalid_i & cnt!=0`.
  - Illegal events are ignored, so the counter never wraps.
- **Age buffer.** A circular buffer of depth MAX_OUTSTANDING holds per-slot age counters and timed-out bits.
  - On accepted grant: write slot at wr_ptr with age=0, to=0.
  - Every cycle: all valid slots increment, saturating at LATENCY_MAX.
  - On accepted rvalid: pop the slot at rd_ptr (oldest; responses are in order).
  - Pointers wrap modulo MAX_OUTSTANDING.
- **Checks.** Each raises `err_o[i]` only if `CHECK_EN[i]` is set.
  - 0 unsolicited response: `apu_rvalid_i & cnt==0`. A grant in the same cycle does not satisfy it, since APU latency is at least 1.
  - 1 overflow: `apu_gnt_i & cnt==MAX_OUTSTANDING & !apu_rvalid_i`.
  - 2 timeout: oldest slot valid, age==LATENCY_MAX-1, to==0, `!apu_rvalid_i`. That slot's to is then set. It reports once per slot and still awaits rvalid.
  - 3 request drop: `apu_req_i & !apu_gnt_i` last cycle, and `!apu_req_i` this cycle.
  - 4 ALU port conflict: `(apu_singlecycle_i|apu_multicycle_i) & apu_en_i & regfile_alu_we_i`.
  - 5 LSU/APU write-back conflict: `regfile_we_lsu_i & apu_rvalid_i & (apu_singlecycle_i|apu_multicycle_i)`.
- **Error capture.**
  - `err_o` is sticky: `err_o <= clear_i ? 0 : err_o | hit`.
  - On the first hit while `!first_err_valid_o`: capture the lowest-index hit into `first_err_id_o` and set `first_err_valid_o`.
  - `clear_i` clears `err_o`, `first_err_valid_o` and `first_err_id_o`.
  - If `clear_i` and a hit occur in the same cycle, clear wins.
  - `clear_i` does not affect the counter or the age buffer.
- `err_any_o` is combinational from the `err_o` register.

## Timing
- Reset values:
  - `err_o`=0, `err_any_o`=0, `first_err_valid_o`=0, `first_err_id_o`=0, `outstanding_o`=0.
  - All age slots invalid; pointers 0; request-drop history 0.
- All checks evaluate inputs at rising edge t. `err_o` is visible from cycle t+1 (one-cycle latency).
- `outstanding_o` reflects accepted events one cycle after the edge.
- Timeout window:
  - Grant accepted at edge t: rvalid is legal at edges t+1..t+LATENCY_MAX.
  - If no rvalid by edge t+LATENCY_MAX, `err_o[2]` rises in cycle t+LATENCY_MAX+1.
- Simultaneous gnt+rvalid:
  - At cnt==MAX: both are accepted, the count is unchanged and there is no overflow.
  - At cnt==0: check 0 fires and the grant is accepted.
- Asynchronous reset mid-transaction drops all tracking immediately. Responses arriving after reset flag check 0.

## Test plan
MAX_OUTSTANDING=2 and LATENCY_MAX=4 for all scenarios.

1. **Normal traffic.** Grant at edge 10, rvalid at edge 13 → `outstanding_o` reads 1 at cycles 11..13 and 0 at 14; `err_o`=0.
2. **Overflow.** Grants at edges 5, 6, 7 with no rvalid → `err_o`=6'b000010 at cycle 8; `first_err_id_o`=1; `outstanding_o` stays 2.
3. **Timeout.** Grant at edge 20, no rvalid → `err_o[2]`=1 from cycle 25, not earlier. Rvalid at edge 30 → `outstanding_o`=0 and no check-0 error.
4. **Unsolicited response plus clear.** Rvalid at edge 3 with cnt 0 → `err_o[0]`=1 from cycle 4. `clear_i` at edge 6 → `err_o`=0 and `first_err_valid_o`=0 from cycle 7.
5. **Simultaneous hits.** Edge 8 presents both a check-4 and a check-5 condition → `err_o`=6'b110000 and `first_err_id_o`=4.
6. **Request drop and mask.** Req high and gnt low at edge 2, req low at edge 3 → `err_o[3]`=1 at cycle 4. Repeat with `CHECK_EN[3]`=0 → no error.
